// File: rtl/digit_scan_ctrl.sv
// Multiplexed LED digit scanner: steps o_sel every CLK_DIV enabled cycles, data snapshotted per frame.
// Latency: o_sel/o_nibble/o_dp/o_frame are registered and change together. Backpressure: i_en low freezes everything.
// Optional dwell-start blanking when SCAN_BLANK_EN is defined (o_blank tied low otherwise).
module digit_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int DIGITS    = 8,
    parameter int BLANK_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic [7:0]  i_dp,
    output logic [2:0]  o_sel,
    output logic [3:0]  o_nibble,
    output logic        o_dp,
    output logic        o_frame,
    output logic        o_blank
);
    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      sel_q, sel_d;
    logic [31:0]     snap_dat_q, snap_dat_d;
    logic [7:0]      snap_dp_q, snap_dp_d;
    logic [3:0]      nibble_q, nibble_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sel_d      = sel_q;
        snap_dat_d = snap_dat_q;
        snap_dp_d  = snap_dp_q;
        frame_d    = 1'b0;
        if (i_en) begin
            case (state_q)
                IDLE: begin
                    state_d    = SCAN;
                    snap_dat_d = i_data;
                    snap_dp_d  = i_dp;
                end
                SCAN: begin
                    if (presc_q == PW'(CLK_DIV - 1)) begin
                        presc_d = '0;
                        if (sel_q == 3'(DIGITS - 1)) begin
                            sel_d      = 3'd0;
                            frame_d    = 1'b1;
                            snap_dat_d = i_data;
                            snap_dp_d  = i_dp;
                        end else begin
                            sel_d = sel_q + 3'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
        // Data is picked from the next select and next snapshot so select and data never skew.
        nibble_d = snap_dat_d[{sel_d, 2'b00} +: 4];
        dp_d     = snap_dp_d[sel_d];
    end

`ifdef SCAN_BLANK_EN
    logic blank_q, blank_d;

    always_comb begin
        blank_d = (state_d == IDLE) || (32'(presc_d) < BLANK_CYC);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) blank_q <= 1'b0;
        else          blank_q <= blank_d;
    end

    assign o_blank = blank_q;
`else
    localparam int unused_blank_cyc = BLANK_CYC;
    assign o_blank = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            sel_q      <= 3'd0;
            snap_dat_q <= '0;
            snap_dp_q  <= '0;
            nibble_q   <= 4'd0;
            dp_q       <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sel_q      <= sel_d;
            snap_dat_q <= snap_dat_d;
            snap_dp_q  <= snap_dp_d;
            nibble_q   <= nibble_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign o_sel    = sel_q;
    assign o_nibble = nibble_q;
    assign o_dp     = dp_q;
    assign o_frame  = frame_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: 8-digit and 4-digit instances, CLK_DIV=4.
module tb_digit_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic        en, en4;
    logic [31:0] data, data4;
    logic [7:0]  dp, dp4;
    logic [2:0]  sel, sel4;
    logic [3:0]  nib, nib4;
    logic        dpo, dpo4, frame, frame4, blank, blank4;

    int n_checks = 0;
    int n_fail   = 0;

    digit_scan_ctrl #(.CLK_DIV(4), .DIGITS(8), .BLANK_CYC(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data), .i_dp(dp),
        .o_sel(sel), .o_nibble(nib), .o_dp(dpo), .o_frame(frame), .o_blank(blank)
    );

    digit_scan_ctrl #(.CLK_DIV(4), .DIGITS(4), .BLANK_CYC(1)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_data(data4), .i_dp(dp4),
        .o_sel(sel4), .o_nibble(nib4), .o_dp(dpo4), .o_frame(frame4), .o_blank(blank4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] prev_sel;
        int         nfr;
        rst_n = 1'b1; en = 1'b0; en4 = 1'b0;
        data  = 32'h7654_3210; dp  = 8'h81;
        data4 = 32'h9876_DCBA; dp4 = 8'h05;

        // Reset asserts asynchronously, before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel", 32'(sel), 0);
        check("rst_nib", 32'(nib), 0);
        check("rst_dp", 32'(dpo), 0);
        check("rst_frame", 32'(frame), 0);
        check("rst_blank", 32'(blank), 0);

        @(negedge clk) rst_n = 1'b1;
        step(2);
        check("idle_hold_sel", 32'(sel), 0);
        check("idle_hold_dp", 32'(dpo), 0);

        // Test 1: one frame of digits, nibble == index, dp at 0 and 7.
        en = 1'b1;
        step(1);
        for (int k = 0; k < 8; k++) begin
            check("t1_sel", 32'(sel), 32'(k));
            check("t1_nib", 32'(nib), 32'(k));
            check("t1_dp", 32'(dpo), (k == 0 || k == 7) ? 32'd1 : 32'd0);
            check("t1_frame_low", 32'(frame), 0);
            step(4);
        end
        check("t1_wrap_frame", 32'(frame), 1);
        check("t1_wrap_sel", 32'(sel), 0);
        check("t1_wrap_nib", 32'(nib), 0);
        check("t1_blank_off", 32'(blank), 0);

        // Test 2: three further frames, one pulse per 32 cycles on the 7->0 wrap.
        prev_sel = sel;
        nfr = 0;
        for (int i = 0; i < 96; i++) begin
            step(1);
            if (frame) begin
                nfr++;
                check("t2_frame_sel", 32'(sel), 0);
                check("t2_frame_prev", 32'(prev_sel), 7);
            end
            prev_sel = sel;
        end
        check("t2_frame_count", 32'(nfr), 3);
        check("t2_end_frame", 32'(frame), 1);

        // Test 3: data change at sel 3 is invisible until the next frame.
        step(12);
        check("t3_at_sel3", 32'(sel), 3);
        data = 32'hFFFF_FFFF;
        for (int k = 3; k < 8; k++) begin
            check("t3_old_sel", 32'(sel), 32'(k));
            check("t3_old_nib", 32'(nib), 32'(k));
            step(4);
        end
        check("t3_wrap_frame", 32'(frame), 1);
        for (int k = 0; k < 8; k++) begin
            check("t3_new_sel", 32'(sel), 32'(k));
            check("t3_new_nib", 32'(nib), 32'hF);
            step(4);
        end

        // Test 4: freeze mid-dwell at sel 5, then finish the remaining two cycles.
        step(20);
        check("t4_at_sel5", 32'(sel), 5);
        step(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t4_frz_sel", 32'(sel), 5);
            check("t4_frz_nib", 32'(nib), 32'hF);
            check("t4_frz_frame", 32'(frame), 0);
        end
        en = 1'b1;
        step(1);
        check("t4_resume_sel5", 32'(sel), 5);
        step(1);
        check("t4_resume_sel6", 32'(sel), 6);

        // Test 5: asynchronous reset between edges, then restart from IDLE.
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_sel", 32'(sel), 0);
        check("t5_rst_nib", 32'(nib), 0);
        check("t5_rst_dp", 32'(dpo), 0);
        check("t5_rst_frame", 32'(frame), 0);
        en = 1'b0;
        data = 32'h7654_3210;
        @(negedge clk) rst_n = 1'b1;
        step(2);
        check("t5_idle_sel", 32'(sel), 0);
        check("t5_idle_nib", 32'(nib), 0);
        en = 1'b1;
        step(1);
        check("t5_start_sel", 32'(sel), 0);
        check("t5_start_dp", 32'(dpo), 1);
        step(4);
        check("t5_next_sel", 32'(sel), 1);
        check("t5_next_nib", 32'(nib), 1);
        check("t5_next_dp", 32'(dpo), 0);

        // Test 6: four-digit build wraps after sel 3; upper nibbles never shown.
        en4 = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            check("t6_sel", 32'(sel4), 32'(k));
            check("t6_nib", 32'(nib4), 32'(10 + k));
            check("t6_dp", 32'(dpo4), (k == 0 || k == 2) ? 32'd1 : 32'd0);
            step(4);
        end
        check("t6_wrap_frame", 32'(frame4), 1);
        check("t6_wrap_sel", 32'(sel4), 0);
        check("t6_wrap_nib", 32'(nib4), 32'hA);
        check("t6_blank_off", 32'(blank4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
